// File: rtl/input_conditioner_pkg.sv
// Shared types and helpers for the input conditioner: press FSM states, counter sizing.
// No logic; latency n/a, no backpressure.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        LONG     = 2'd2
    } btn_state_t;

    // Bits needed to hold 0..max_val; never zero so a max of 0 still gets a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw inputs and conditioned outputs of the input conditioner, one bit per channel.
// Pure wiring; no handshake, outputs are free-running registered pulses/levels.
interface input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;
    logic [WIDTH-1:0] long_pulse;

    modport master (
        output in,
        input  level, press_pulse, release_pulse, long_pulse
    );

    modport slave (
        input  in,
        output level, press_pulse, release_pulse, long_pulse
    );
endinterface

// File: rtl/input_conditioner_channel.sv
// One channel: tick-paced debounce counter, debounced level and RELEASED/PRESSED/LONG FSM.
// Outputs registered, pulses one cycle after the deciding tick edge; no backpressure.
module input_conditioner_channel
    import input_conditioner_pkg::*;
#(
    parameter int PULSE_CNT_MAX = 200,
    parameter int LONG_CNT_MAX  = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sync_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DW = cnt_width(PULSE_CNT_MAX);
    localparam int HW = cnt_width(LONG_CNT_MAX);
    localparam logic [DW:0] DB_TGT   = (DW+1)'(PULSE_CNT_MAX);
    localparam logic [HW:0] HOLD_TGT = (HW+1)'(LONG_CNT_MAX);

    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    btn_state_t    state;

    logic [DW:0] db_inc;
    logic [HW:0] hold_inc;
    logic        flip;
    logic        rise;
    logic        fall;
    logic        long_hit;

    always_comb begin
        db_inc   = {1'b0, db_cnt} + (DW+1)'(1);
        hold_inc = {1'b0, hold_cnt} + (HW+1)'(1);
        flip     = tick && (sync_in != level) && (db_inc == DB_TGT);
        rise     = flip && !level;
        fall     = flip && level;
        long_hit = (LONG_CNT_MAX > 0) && (hold_inc == HOLD_TGT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level         <= 1'b0;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            state         <= RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            if (tick) begin
                if (flip || (sync_in == level)) begin
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_inc[DW-1:0];
                end
                if (flip) begin
                    level <= ~level;
                end
                case (state)
                    RELEASED: begin
                        if (rise) begin
                            state       <= PRESSED;
                            press_pulse <= 1'b1;
                            hold_cnt    <= '0;
                        end
                    end
                    PRESSED: begin
                        // A release on the threshold tick suppresses the long event.
                        if (fall) begin
                            state         <= RELEASED;
                            release_pulse <= 1'b1;
                        end else begin
                            if (hold_inc <= HOLD_TGT) begin
                                hold_cnt <= hold_inc[HW-1:0];
                            end
                            if (long_hit) begin
                                state      <= LONG;
                                long_pulse <= 1'b1;
                            end
                        end
                    end
                    LONG: begin
                        if (fall) begin
                            state         <= RELEASED;
                            release_pulse <= 1'b1;
                        end
                    end
                    default: state <= RELEASED;
                endcase
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises WIDTH raw inputs, paces them with a shared sample tick and debounces each channel.
// Sync latency SYNC_STAGES clocks, then PULSE_CNT_MAX ticks to a level change; no backpressure.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 30000,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int LONG_CNT_MAX   = 4000
) (
    input logic                clk,
    input logic                rst,
    input_conditioner_if.slave io
);

    localparam int SCW = cnt_width(SAMPLE_CNT_MAX);
    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLE_CNT_MAX - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [SCW-1:0]                    sample_cnt;
    logic                              tick;

    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] press_w;
    logic [WIDTH-1:0] release_w;
    logic [WIDTH-1:0] long_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io.in};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign tick = (sample_cnt == SAMPLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SCW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        input_conditioner_channel #(
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .LONG_CNT_MAX  (LONG_CNT_MAX)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .tick          (tick),
            .sync_in       (sync[i]),
            .level         (level_w[i]),
            .press_pulse   (press_w[i]),
            .release_pulse (release_w[i]),
            .long_pulse    (long_w[i])
        );
    end

    assign io.level         = level_w;
    assign io.press_pulse   = press_w;
    assign io.release_pulse = release_w;
    assign io.long_pulse    = long_w;

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
REQ-003 Parameter SAMPLE_CNT_MAX, default 30000: clocks per sample tick, minimum 1.
REQ-004 Parameter PULSE_CNT_MAX, default 200: consecutive disagreeing ticks needed to change debounced level, minimum 1.
REQ-005 Parameter LONG_CNT_MAX, default 4000: ticks after press until long-press; 0 disables long detection.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in  input  WIDTH  raw asynchronous inputs, e.g. buttons or switches.
REQ-009 level  output  WIDTH  debounced level per channel.
REQ-010 press_pulse  output  WIDTH  one-cycle pulse on debounced 0->1.
REQ-011 release_pulse  output  WIDTH  one-cycle pulse on debounced 1->0.
REQ-012 long_pulse  output  WIDTH  one-cycle pulse when a press has been held LONG_CNT_MAX ticks.

Function
REQ-013 Each channel SHALL pass through a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
REQ-014 One shared sample counter SHALL count 0..SAMPLE_CNT_MAX-1 and wrap; tick = (count == SAMPLE_CNT_MAX-1), combinational, one cycle per period.
REQ-015 Channel logic SHALL update only on edges where tick is high; between ticks, counters and level hold.
REQ-016 On tick, if sync[i] == level[i], debounce counter SHALL clear to 0.
REQ-017 On tick, if sync[i] != level[i] and counter+1 < PULSE_CNT_MAX, counter SHALL increment.
REQ-018 On tick, if sync[i] != level[i] and counter+1 == PULSE_CNT_MAX, level[i] SHALL toggle and counter SHALL clear, all on that edge.
REQ-019 Per-channel FSM SHALL have states RELEASED, PRESSED and LONG; reset state is RELEASED.
REQ-020 Transition RELEASED->PRESSED on debounced rise: assert press_pulse and clear hold counter.
REQ-021 In PRESSED, each tick without a debounced fall SHALL increment the hold counter.
REQ-022 In PRESSED, when the hold counter reaches LONG_CNT_MAX (LONG_CNT_MAX > 0): go to LONG and assert long_pulse.
REQ-023 In PRESSED or LONG, a debounced fall SHALL go to RELEASED and assert release_pulse.
REQ-024 A debounced fall on the same tick as the long threshold SHALL win: no long_pulse.
REQ-025 The hold counter SHALL saturate; it never wraps, and long_pulse fires at most once per press.
REQ-026 All outputs SHALL be registered; each pulse SHALL be high for exactly one clk cycle, the cycle after the deciding edge.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels all produce their pulses in the same cycle.
REQ-028 Counter widths SHALL be $clog2(max+1); no truncation at the maximum parameter values.

Reset
REQ-029 While rst is high: sync chains, sample counter, all channel counters and level SHALL be 0; all pulses 0; FSMs RELEASED.
REQ-030 Reset mid-press SHALL abort the press silently: no release_pulse; an input still held SHALL be re-detected as a fresh press.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (RELEASED, PRESSED, LONG) and the counter-width helper.
REQ-032 One sub-module, input_conditioner_channel, SHALL hold the per-channel debounce counter, FSM and hold counter; it is instantiated WIDTH times by a generate loop.
REQ-033 The synchronizer chain and the shared tick counter SHALL live in the top level.

Verification (WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, LONG_CNT_MAX=5; edges numbered from 1 after rst falls)
REQ-034 in[0] held 1 from reset release -> ticks at edges 4, 8, 12; level[0] rises at edge 12; press_pulse[0] high for that one cycle only.
REQ-035 Same stimulus, held on -> long_pulse[0] at edge 32 (5 ticks after the press), once; no repeat by edge 100.
REQ-036 in[1] high for 2 ticks, then low -> level[1] stays 0; no pulses on any output.
REQ-037 Release timed so the debounced fall lands on the threshold tick of the long count -> release_pulse only; long_pulse stays 0.
REQ-038 Both channels rise in the same cycle -> press_pulse == 2'b11 in the same cycle.
REQ-039 Assert rst while level[0]=1 with in[0] still held -> all outputs 0 immediately; no release_pulse; press_pulse[0] again 12 edges after release.
